// File: rtl/irq_ctrl_if.sv
// Bus bundle between the interrupt controller and the exception controller.
// The master drives sources, mask writes and handshakes; the slave is irq_ctrl.
interface irq_ctrl_if #(
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0] irq_src;
  logic            mask_we;
  logic [NSRC-1:0] mask_wd;
  logic            ExtIAck;
  logic            ERet;
  logic            ExtIRQ;
  logic [2:0]      irq_id;
  logic [NSRC-1:0] irq_pending;
  logic [NSRC-1:0] irq_mask;
  logic            in_service;

  modport master (
    output irq_src, mask_we, mask_wd, ExtIAck, ERet,
    input  ExtIRQ, irq_id, irq_pending, irq_mask, in_service
  );

  modport slave (
    input  irq_src, mask_we, mask_wd, ExtIAck, ERet,
    output ExtIRQ, irq_id, irq_pending, irq_mask, in_service
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered external interrupt controller: synchronizes raw lines, latches
// pending edges, and arbitrates one fixed-priority request at a time.
module irq_ctrl #(
  parameter int unsigned NSRC = 4
) (
  input  logic     clk,
  input  logic     reset,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] sync1_q, sync1_d;
  logic [NSRC-1:0] sync2_q, sync2_d;
  logic [NSRC-1:0] prev_q, prev_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [2:0]      id_q, id_d;
  logic            extirq_q, extirq_d;
  logic            insvc_q, insvc_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] id_onehot;
  logic [NSRC-1:0] clr;
  logic            found;

  always_comb begin
    sync1_d   = bus.irq_src;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    rise      = sync2_q & ~prev_q;
    active    = pend_q & mask_q;
    id_onehot = NSRC'(1) << id_q;
    mask_d    = bus.mask_we ? bus.mask_wd : mask_q;
    state_d   = state_q;
    id_d      = id_q;
    clr       = '0;
    found     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|active) begin
          state_d = S_REQ;
          for (int unsigned i = 0; i < NSRC; i++) begin
            if (active[i] && !found) begin
              id_d  = 3'(i);
              found = 1'b1;
            end
          end
        end
      end
      S_REQ: begin
        // Ack has priority over a mask write that withdraws the request.
        if (bus.ExtIAck) begin
          clr     = id_onehot;
          state_d = S_SERVICE;
        end else if (~|(mask_q & id_onehot)) begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (bus.ERet) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh edge on the acked source survives the clear.
    pend_d   = (pend_q & ~clr) | rise;
    extirq_d = (state_d == S_REQ);
    insvc_d  = (state_d == S_SERVICE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      id_q     <= '0;
      extirq_q <= 1'b0;
      insvc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      id_q     <= id_d;
      extirq_q <= extirq_d;
      insvc_q  <= insvc_d;
    end
  end

  assign bus.ExtIRQ      = extirq_q;
  assign bus.in_service  = insvc_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pend_q;
  assign bus.irq_mask    = mask_q;

endmodule
